// File: rtl/adder_pkg.sv
// Shared types and defaults for the registered ripple-carry adder.
// The ADDER_OVF_EN macro is consumed by adder_four_bit.
package adder_pkg;

  localparam int ADDER_DEFAULT_WIDTH = 4;
  localparam int ADDER_MAX_WIDTH     = 32;

  typedef logic [ADDER_DEFAULT_WIDTH-1:0] sum_t;

  typedef struct packed {
    logic carry;
    sum_t sum;
  } adder_res_t;

endpackage

// File: rtl/full_adder_bit.sv
// Single full-adder cell used to build the ripple chain.
// Pure combinational logic.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/adder_four_bit.sv
// Registered ripple-carry adder, one cycle latency.
// Define ADDER_OVF_EN to add the registered signed-overflow output ovf.
module adder_four_bit
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             Cout,
`ifdef ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  typedef struct packed {
    logic             carry;
    logic [WIDTH-1:0] sum;
  } res_t;

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  res_t             res;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder_bit u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign res.carry = c[WIDTH];
  assign res.sum   = s;

  // Operands are only captured when qualified; idle cycles hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= res.sum;
        Cout <= res.carry;
      end
    end
  end

`ifdef ADDER_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (in_valid) begin
      ovf <= c[WIDTH] ^ c[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_adder_four_bit.sv
// Self-checking bench: WIDTH=4 and WIDTH=8 instances against
// a plain-arithmetic reference model.
module tb_adder_four_bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a, b, sum;
  logic [7:0] a8, b8, sum8;
  logic       cout, cout8, ov, ov8;
`ifdef ADDER_OVF_EN
  logic       ovf, ovf8;
`endif

  int checks = 0;
  int failures = 0;

  logic [4:0] m4;
  logic [8:0] m8;
  logic       mv;
`ifdef ADDER_OVF_EN
  logic       mo4, mo8;
`endif

  always #5 clk = ~clk;

  adder_four_bit #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .sum       (sum),
    .Cout      (cout),
`ifdef ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .out_valid (ov)
  );

  adder_four_bit #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a8),
    .b         (b8),
    .sum       (sum8),
    .Cout      (cout8),
`ifdef ADDER_OVF_EN
    .ovf       (ovf8),
`endif
    .out_valid (ov8)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sgn(input int v, input int w);
    return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
  endfunction

  task automatic compare();
    chk("vld4", 32'(ov), 32'(mv));
    chk("res4", 32'({cout, sum}), 32'(m4));
    chk("vld8", 32'(ov8), 32'(mv));
    chk("res8", 32'({cout8, sum8}), 32'(m8));
`ifdef ADDER_OVF_EN
    chk("ovf4", 32'(ovf), 32'(mo4));
    chk("ovf8", 32'(ovf8), 32'(mo8));
`endif
  endtask

  task automatic step(input logic v, input int x, input int y,
                      input int x8, input int y8);
    in_valid = v;
    a  = 4'(x);
    b  = 4'(y);
    a8 = 8'(x8);
    b8 = 8'(y8);
    mv = v;
    if (v) begin
      m4 = 5'(x + y);
      m8 = 9'(x8 + y8);
`ifdef ADDER_OVF_EN
      mo4 = (sgn(x, 4) + sgn(y, 4) > 7) || (sgn(x, 4) + sgn(y, 4) < -8);
      mo8 = (sgn(x8, 8) + sgn(y8, 8) > 127) ||
            (sgn(x8, 8) + sgn(y8, 8) < -128);
`endif
    end
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  task automatic model_reset();
    m4 = '0;
    m8 = '0;
    mv = 1'b0;
`ifdef ADDER_OVF_EN
    mo4 = 1'b0;
    mo8 = 1'b0;
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0; b = '0; a8 = '0; b8 = '0;
    model_reset();
    #2;
    compare();
    @(negedge clk);
    rst_n = 1'b1;

    step(1, 0, 1, 0, 1);
    step(1, 1, 1, 200, 100);
    step(1, 2, 1, 255, 1);
    step(1, 4, 5, 64, 64);
    step(1, 12, 13, 128, 128);
    step(1, 15, 1, 127, 1);
    step(1, 15, 15, 255, 255);
    step(1, 0, 0, 0, 0);

    step(1, 3, 3, 3, 3);
    for (int i = 0; i < 5; i++)
      step(0, $urandom_range(15), $urandom_range(15),
           $urandom_range(255), $urandom_range(255));

    // Async reset while a result is valid, checked before any edge.
    step(1, 9, 9, 99, 99);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 7, 8, 17, 18);

    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        step(1, x, y, $urandom_range(255), $urandom_range(255));

    for (int i = 0; i < 200; i++)
      step(($urandom_range(3) != 0), $urandom_range(15),
           $urandom_range(15), $urandom_range(255), $urandom_range(255));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_four_bit.md
Name: adder_four_bit

Overview:
- Registered ripple-carry adder; default width 4 bits. Produces `a + b` as an N-bit sum plus a carry-out.
- Used as a leaf arithmetic block in the datapath.
- Inputs are sampled on a qualifying clock edge. Results appear one cycle later with a valid flag.

Parameters:
- WIDTH, 4, operand and sum width in bits (legal range 1 to 32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies a and b for sampling this cycle.
- a  input  WIDTH  unsigned operand A.
- b  input  WIDTH  unsigned operand B.
- sum  output  WIDTH  registered low WIDTH bits of a+b.
- Cout  output  1  registered carry-out (bit WIDTH of a+b).
- out_valid  output  1  high for exactly one cycle per accepted input.

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low (clk, rst_n).
  - While rst_n=0: sum=0, Cout=0, out_valid=0, taking effect immediately without a clock edge.
  - Deassertion is synchronised externally; the block needs no internal synchroniser.
- Datapath:
  - Combinational ripple chain of WIDTH full-adder cells.
  - Carry-in to bit 0 is 0.
  - Each cell computes s_i = a_i ^ b_i ^ c_i and c_{i+1} = a_i&b_i | a_i&c_i | b_i&c_i.
  - Cout = c_WIDTH.
- Latency and registers:
  - Latency is 1 cycle.
  - On a rising clk with in_valid=1: sum and Cout register the chain result, and out_valid <= 1.
  - On a rising clk with in_valid=0: sum and Cout hold their previous value, and out_valid <= 0.
- Handshake: no backpressure. Every in_valid=1 cycle is accepted, so back-to-back inputs give back-to-back outputs at full throughput.
- Arithmetic:
  - Unsigned, no saturation.
  - {Cout,sum} = a+b exactly, with range 0 to 2^(WIDTH+1)-2.
  - Wrap case: sum holds the low bits and Cout=1.
- Boundaries:
  - all-ones + 1 -> sum=0, Cout=1.
  - 0+0 -> sum=0, Cout=0.
  - all-ones + all-ones -> sum=all-ones minus 1, Cout=1.
- Reset mid-operation: a result in flight is discarded and out_valid is forced to 0 immediately. The first in_valid after reset release is processed normally.
- X handling: a and b are ignored when in_valid=0. The output registers must not capture them.

Optional Feature:
- Macro: ADDER_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), registered alongside sum.
  - ovf = c_WIDTH ^ c_(WIDTH-1), the two's-complement signed overflow.
  - ovf resets to 0 and holds when in_valid=0.
  - Example: 0100+0101 -> ovf=1.
- When undefined: the port and its logic are absent; all other behaviour is unchanged.

Decomposition:
- Shared package adder_pkg:
  - ADDER_DEFAULT_WIDTH = 4.
  - typedef for the {carry,sum} result struct (sum_t of WIDTH bits, carry bit).
- One sub-module, full_adder_bit (inputs a, b, cin; outputs s, cout).
  - WIDTH instances are placed by a generate loop in adder_four_bit.
- Output registers live in the top module.

Test Plan:
- Reset: assert rst_n=0 mid-run with out_valid=1 -> sum=0, Cout=0, out_valid=0 immediately, before the next clk edge.
- Directed basic sequence, WIDTH=4, in_valid=1, one per cycle; each result appears one cycle later with out_valid=1:
  - a=0, b=1 -> sum=1, Cout=0.
  - a=1, b=1 -> sum=2, Cout=0.
  - a=2, b=1 -> sum=3, Cout=0.
- Mid-range, no carry-out: a=4 (0100), b=5 (0101) -> sum=9 (1001), Cout=0; with ADDER_OVF_EN, ovf=1.
- Carry-out: a=12 (1100), b=13 (1101) -> sum=9 (1001), Cout=1; a=15, b=1 -> sum=0, Cout=1; a=15, b=15 -> sum=14, Cout=1.
- Hold: apply a=3, b=3 with in_valid=1, then toggle a and b randomly with in_valid=0 for 5 cycles -> sum stays 6, Cout stays 0, out_valid=0 after the first cycle.
- Exhaustive: all 256 (a,b) pairs back-to-back with in_valid=1 -> {Cout,sum} equals a+b one cycle later every cycle; also repeat with WIDTH=8 on random vectors.
